fetch_unit: RTL and testbench

Instruction-fetch front end of the MIPS pipeline: owns the program counter, drives the read port of the instruction ROM, and registers the returned word into the IF/ID pipeline register. It is the initiator side of the ROM interface, a combinational responder. Stall, branch-redirect and flush requests from the control and decode stages are resolved here each cycle.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/fetch_unit_if.sv | 12 +
 rtl/fetch_unit_pc_reg.sv | 60 ++++++
 rtl/fetch_unit.sv | 78 +++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the fetch front end.
package cpu_pkg;

    typedef logic [31:0] inst_t;
    typedef logic [31:0] addr_t;

    localparam inst_t NOP_INST    = 32'h0000_0000;
    localparam int    STALL_PC    = 0;
    localparam int    STALL_IFID  = 1;
    localparam logic  CHIPENABLE  = 1'b1;
    localparam logic  CHIPDISABLE = 1'b0;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

    // Redirect addresses may arrive with junk in the byte-offset bits.
    function automatic addr_t word_align(input addr_t a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction ROM read port: fetch unit drives address/enable, ROM answers combinationally.
interface fetch_unit_if;
    import cpu_pkg::*;

    logic  rom_re;
    addr_t rom_addr;
    inst_t rom_inst;

    modport master (output rom_re, output rom_addr, input rom_inst);
    modport slave  (input rom_re, input rom_addr, output rom_inst);

endinterface

// File: rtl/fetch_unit_pc_reg.sv
// Program counter with the IDLE/FETCH enable FSM and flush > stall > branch > +4 priority.
module pc_reg
    import cpu_pkg::*;
#(
    parameter addr_t RESET_PC = 32'h0000_0000
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  stall_pc,
    input  logic  flush,
    input  addr_t flush_pc,
    input  logic  branch_flag,
    input  addr_t branch_target,
    output addr_t pc,
    output logic  fetch_en
);

    fetch_state_e state_r;
    addr_t        pc_r;
    logic         fetch_en_r;

    // Enable FSM and PC register; the PC holds on the IDLE->FETCH edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= FETCH_IDLE;
            pc_r       <= RESET_PC;
            fetch_en_r <= CHIPDISABLE;
        end else begin
            case (state_r)
                FETCH_IDLE: begin
                    state_r    <= FETCH_RUN;
                    fetch_en_r <= CHIPENABLE;
                    pc_r       <= pc_r;
                end
                FETCH_RUN: begin
                    state_r    <= FETCH_RUN;
                    fetch_en_r <= CHIPENABLE;
                    if (flush) begin
                        pc_r <= word_align(flush_pc);
                    end else if (stall_pc) begin
                        pc_r <= pc_r;
                    end else if (branch_flag) begin
                        pc_r <= word_align(branch_target);
                    end else begin
                        pc_r <= pc_r + 32'd4;
                    end
                end
                default: begin
                    state_r    <= FETCH_IDLE;
                    fetch_en_r <= CHIPDISABLE;
                    pc_r       <= RESET_PC;
                end
            endcase
        end
    end

    assign pc       = pc_r;
    assign fetch_en = fetch_en_r;

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC, ROM read port and IF/ID register.
// Optional DELAY_SLOT_EN: the word fetched alongside a taken branch enters IF/ID instead of being squashed.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter addr_t RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          stall,
    input  logic                flush,
    input  addr_t               flush_pc,
    input  logic                branch_flag,
    input  addr_t               branch_target,
    fetch_unit_if.master        rom,
    output addr_t               id_pc,
    output inst_t               id_inst,
    output logic                id_valid
);

    addr_t pc_s;
    logic  fetch_en_s;
    logic  squash_s;
    addr_t id_pc_r;
    inst_t id_inst_r;
    logic  id_valid_r;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .stall_pc      (stall[STALL_PC]),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .pc            (pc_s),
        .fetch_en      (fetch_en_s)
    );

    assign rom.rom_addr = pc_s;
    assign rom.rom_re   = fetch_en_s;

`ifdef DELAY_SLOT_EN
    assign squash_s = 1'b0;
`else
    assign squash_s = branch_flag;
`endif

    // IF/ID register: flush > hold > bubble sources > capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc_r    <= 32'h0000_0000;
            id_inst_r  <= NOP_INST;
            id_valid_r <= 1'b0;
        end else if (flush) begin
            id_pc_r    <= 32'h0000_0000;
            id_inst_r  <= NOP_INST;
            id_valid_r <= 1'b0;
        end else if (stall[STALL_IFID]) begin
            id_pc_r    <= id_pc_r;
            id_inst_r  <= id_inst_r;
            id_valid_r <= id_valid_r;
        end else if (stall[STALL_PC] || (fetch_en_s == CHIPDISABLE) || squash_s) begin
            id_pc_r    <= 32'h0000_0000;
            id_inst_r  <= NOP_INST;
            id_valid_r <= 1'b0;
        end else begin
            id_pc_r    <= pc_s;
            id_inst_r  <= rom.rom_inst;
            id_valid_r <= 1'b1;
        end
    end

    assign id_pc    = id_pc_r;
    assign id_inst  = id_inst_r;
    assign id_valid = id_valid_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (reset, stall, branch, flush, wrap, async reset).
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  stall;
    logic        flush;
    addr_t       flush_pc;
    logic        branch_flag;
    addr_t       branch_target;
    addr_t       id_pc0, id_pc1;
    inst_t       id_inst0, id_inst1;
    logic        id_valid0, id_valid1;
    int          checks;
    int          errors;

    fetch_unit_if rom0 ();
    fetch_unit_if rom1 ();

    function automatic inst_t rom_word(input addr_t a);
        case (a)
            32'h0000_0000: return 32'h0000_0011;
            32'h0000_0004: return 32'h0000_0022;
            32'h0000_0008: return 32'h0000_0033;
            default:       return 32'hC000_0000 | a;
        endcase
    endfunction

    assign rom0.rom_inst = rom_word(rom0.rom_addr);
    assign rom1.rom_inst = rom_word(rom1.rom_addr);

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
        .branch_flag(branch_flag), .branch_target(branch_target), .rom(rom0),
        .id_pc(id_pc0), .id_inst(id_inst0), .id_valid(id_valid0)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .rst(rst), .stall(2'b00), .flush(1'b0), .flush_pc(32'h0000_0000),
        .branch_flag(1'b0), .branch_target(32'h0000_0000), .rom(rom1),
        .id_pc(id_pc1), .id_inst(id_inst1), .id_valid(id_valid1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_id(input string tag, input addr_t pc, input inst_t inst, input logic valid);
        check_eq({tag, ".id_pc"}, id_pc0, pc);
        check_eq({tag, ".id_inst"}, id_inst0, inst);
        check_eq({tag, ".id_valid"}, {31'd0, id_valid0}, {31'd0, valid});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        stall         = 2'b00;
        flush         = 1'b0;
        flush_pc      = 32'h0000_0000;
        branch_flag   = 1'b0;
        branch_target = 32'h0000_0000;
        step();
        step();
        check_eq("rst.rom_re", {31'd0, rom0.rom_re}, 32'd0);
        check_eq("rst.rom_addr", rom0.rom_addr, 32'h0000_0000);
        check_id("rst", 32'h0, NOP_INST, 1'b0);
        rst = 1'b1;

        // IDLE -> FETCH, then in-order fetch
        step();
        check_eq("en.rom_re", {31'd0, rom0.rom_re}, 32'd1);
        check_eq("en.rom_addr", rom0.rom_addr, 32'h0000_0000);
        check_id("en", 32'h0, NOP_INST, 1'b0);
        check_eq("wrap.a0", rom1.rom_addr, 32'hFFFF_FFF8);
        step();
        check_eq("run1.rom_addr", rom0.rom_addr, 32'h0000_0004);
        check_id("run1", 32'h0, 32'h11, 1'b1);
        check_eq("wrap.a1", rom1.rom_addr, 32'hFFFF_FFFC);
        step();
        check_eq("run2.rom_addr", rom0.rom_addr, 32'h0000_0008);
        check_id("run2", 32'h4, 32'h22, 1'b1);
        check_eq("wrap.a2", rom1.rom_addr, 32'h0000_0000);
        check_eq("wrap.id_pc", id_pc1, 32'hFFFF_FFFC);

        // Full stall for three cycles at PC=8
        stall = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall11.rom_addr", rom0.rom_addr, 32'h0000_0008);
            check_id("stall11", 32'h4, 32'h22, 1'b1);
        end
        stall = 2'b01;
        step();
        check_eq("stall01.rom_addr", rom0.rom_addr, 32'h0000_0008);
        check_id("stall01", 32'h0, NOP_INST, 1'b0);
        stall = 2'b00;
        step();
        check_eq("resume.rom_addr", rom0.rom_addr, 32'h0000_000C);
        check_id("resume", 32'h8, 32'h33, 1'b1);
        step();
        check_eq("run3.rom_addr", rom0.rom_addr, 32'h0000_0010);
        check_id("run3", 32'hC, 32'hC000_000C, 1'b1);

        // Branch while fetching 0x10
        branch_flag   = 1'b1;
        branch_target = 32'h0000_0040;
        step();
        branch_flag = 1'b0;
        check_eq("br.rom_addr", rom0.rom_addr, 32'h0000_0040);
`ifdef DELAY_SLOT_EN
        check_id("br", 32'h10, 32'hC000_0010, 1'b1);
`else
        check_id("br", 32'h0, NOP_INST, 1'b0);
`endif
        step();
        check_eq("brtgt.rom_addr", rom0.rom_addr, 32'h0000_0044);
        check_id("brtgt", 32'h40, 32'hC000_0040, 1'b1);

        // Misaligned branch target is word aligned
        branch_flag   = 1'b1;
        branch_target = 32'h0000_0043;
        step();
        branch_flag = 1'b0;
        check_eq("bralign.rom_addr", rom0.rom_addr, 32'h0000_0040);
        step();
        check_id("bralign2", 32'h40, 32'hC000_0040, 1'b1);

        // Flush beats stall and branch together
        flush         = 1'b1;
        flush_pc      = 32'h0000_0180;
        stall         = 2'b11;
        branch_flag   = 1'b1;
        branch_target = 32'h0000_0040;
        step();
        flush = 1'b0; stall = 2'b00; branch_flag = 1'b0;
        check_eq("flush.rom_addr", rom0.rom_addr, 32'h0000_0180);
        check_id("flush", 32'h0, NOP_INST, 1'b0);
        step();
        check_eq("postflush.rom_addr", rom0.rom_addr, 32'h0000_0184);
        check_id("postflush", 32'h180, 32'hC000_0180, 1'b1);

        // Branch together with PC stall is dropped
        branch_flag   = 1'b1;
        branch_target = 32'h0000_0080;
        stall         = 2'b01;
        step();
        branch_flag = 1'b0; stall = 2'b00;
        check_eq("brlost.rom_addr", rom0.rom_addr, 32'h0000_0184);
        check_id("brlost", 32'h0, NOP_INST, 1'b0);
        step();
        check_eq("brlost2.rom_addr", rom0.rom_addr, 32'h0000_0188);
        check_id("brlost2", 32'h184, 32'hC000_0184, 1'b1);

        // Misaligned flush address
        flush    = 1'b1;
        flush_pc = 32'h0000_0203;
        step();
        flush = 1'b0;
        check_eq("flalign.rom_addr", rom0.rom_addr, 32'h0000_0200);

        // Asynchronous reset in the middle of a stall
        step();
        stall = 2'b11;
        step();
        check_id("prerst", 32'h200, 32'hC000_0200, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst.rom_re", {31'd0, rom0.rom_re}, 32'd0);
        check_eq("arst.rom_addr", rom0.rom_addr, 32'h0000_0000);
        check_id("arst", 32'h0, NOP_INST, 1'b0);
        check_eq("arst.wrap_addr", rom1.rom_addr, 32'hFFFF_FFF8);
        stall = 2'b00;
        step();
        rst = 1'b1;
        step();
        check_eq("rerun.rom_re", {31'd0, rom0.rom_re}, 32'd1);
        check_eq("rerun.rom_addr", rom0.rom_addr, 32'h0000_0000);
        check_id("rerun", 32'h0, NOP_INST, 1'b0);
        step();
        check_eq("rerun1.rom_addr", rom0.rom_addr, 32'h0000_0004);
        check_id("rerun1", 32'h0, 32'h11, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
